// File: rtl/mem_pkg.sv
// Shared definitions for sync_ram: access-size encodings, FSM states and byte-count helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        LEN_BYTE   = 2'd0,
        LEN_HALF   = 2'd1,
        LEN_WORD   = 2'd2,
        LEN_DOUBLE = 2'd3
    } len_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Total bytes touched by a whole transaction (DOUBLEWORD spans two beats).
    function automatic logic [3:0] byteCount(input len_e len);
        case (len)
            LEN_BYTE: return 4'd1;
            LEN_HALF: return 4'd2;
            LEN_WORD: return 4'd4;
            default:  return 4'd8;
        endcase
    endfunction

    function automatic logic [2:0] beatBytes(input len_e len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_array.sv
// Byte-addressable storage split into four byte lanes, so any 4-byte window
// (aligned or not) is read or written in one cycle. No reset on contents.
module ram_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    output logic [31:0]       o_rdata
);
    localparam int ROWS = 2 ** (ADDR_W - 2);

    logic [7:0] w_wbyte  [4];
    logic [7:0] w_laneRd [4];
    logic [1:0] r_off;

    // Position 0 is the first (lowest-address, most significant) byte.
    for (genvar p = 0; p < 4; p++) begin : g_wbyte
        assign w_wbyte[p] = i_wdata[8*(3-p) +: 8];
    end

    for (genvar L = 0; L < 4; L++) begin : g_lane
        logic [1:0]        w_pos;
        logic [ADDR_W-1:0] w_byteAddr;
        logic [ADDR_W-3:0] w_row;
        logic [7:0]        r_mem [ROWS];
        logic [7:0]        r_rd;

        assign w_pos      = 2'(L) - i_addr[1:0];
        assign w_byteAddr = i_addr + ADDR_W'(w_pos);
        assign w_row      = w_byteAddr[ADDR_W-1:2];
        assign w_laneRd[L] = r_rd;

        always_ff @(posedge clk) begin
            if (i_we[w_pos]) begin
                r_mem[w_row] <= w_wbyte[w_pos];
            end
            if (i_re) begin
                r_rd <= r_mem[w_row];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_off <= i_addr[1:0];
        end
    end

    // Rotate lanes back into big-endian byte order using the offset of the last read.
    always_comb begin
        o_rdata = '0;
        for (int p = 0; p < 4; p++) begin
            o_rdata[8*(3-p) +: 8] = w_laneRd[r_off + 2'(p)];
        end
    end

endmodule

// File: rtl/sync_ram.sv
// Wait-state byte RAM with BYTE..DOUBLEWORD big-endian accesses and moc handshake.
// Define SYNC_RAM_ALIGN_CHECK_EN to reject misaligned HALFWORD/WORD/DOUBLEWORD accesses.
module sync_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_write,
    input  logic [1:0]        data_length,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              beat_valid,
    output logic              moc,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_beat;
    logic              r_rw;
    len_e              r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic              r_beatValid;
    logic [2:0]        r_outBytes;

    logic [ADDR_W:0]   w_end;
    logic              w_misalign, w_bad, w_access;
    logic [ADDR_W-1:0] w_ramAddr;
    logic [31:0]       w_src, w_wdata, w_rdata;
    logic [3:0]        w_laneMask, w_we;
    logic              w_re;

    // Bad accesses are decided from the latched request so err stays stable in DONE.
    assign w_end = {1'b0, r_addr} + (ADDR_W+1)'(byteCount(r_len));
`ifdef SYNC_RAM_ALIGN_CHECK_EN
    assign w_misalign = ((r_len == LEN_HALF) && r_addr[0]) ||
                        ((r_len == LEN_WORD || r_len == LEN_DOUBLE) && (r_addr[1:0] != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_bad = (w_end > DEPTH) || w_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (enable) w_next = (WAIT_CYCLES == 0) ? BEAT : WAIT;
            WAIT: begin
                if (!enable)              w_next = IDLE;
                else if (r_cnt < 4'd2)    w_next = BEAT;
            end
            BEAT: begin
                if (!enable)                                       w_next = IDLE;
                else if (w_bad || r_beat || r_len != LEN_DOUBLE)   w_next = DONE;
                else                                               w_next = (WAIT_CYCLES == 0) ? BEAT : WAIT;
            end
            DONE: if (!enable) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_beat      <= 1'b0;
            r_rw        <= 1'b0;
            r_len       <= LEN_BYTE;
            r_addr      <= '0;
            r_din       <= '0;
            r_beatValid <= 1'b0;
            r_outBytes  <= '0;
        end else begin
            r_beatValid <= 1'b0;
            case (r_state)
                IDLE: if (enable) begin
                    r_rw   <= read_write;
                    r_len  <= len_e'(data_length);
                    r_addr <= address;
                    r_din  <= data_in;
                    r_cnt  <= 4'(WAIT_CYCLES);
                    r_beat <= 1'b0;
                end
                WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                BEAT: if (w_access) begin
                    r_beatValid <= 1'b1;
                    r_beat      <= 1'b1;
                    r_cnt       <= 4'(WAIT_CYCLES);
                    if (r_rw) r_outBytes <= beatBytes(r_len);
                end
                default: ;
            endcase
        end
    end

    // Memory port control and output decode; beat 1 of a DOUBLEWORD takes live data_in.
    always_comb begin
        w_access  = (r_state == BEAT) && enable && !w_bad;
        w_ramAddr = r_addr + (r_beat ? ADDR_W'(4) : ADDR_W'(0));
        w_src     = r_beat ? data_in : r_din;
        case (r_len)
            LEN_BYTE: begin w_wdata = {w_src[7:0], 24'd0};  w_laneMask = 4'b0001; end
            LEN_HALF: begin w_wdata = {w_src[15:0], 16'd0}; w_laneMask = 4'b0011; end
            default:  begin w_wdata = w_src;                w_laneMask = 4'b1111; end
        endcase
        w_we = (w_access && !r_rw) ? w_laneMask : 4'b0000;
        w_re = w_access && r_rw;
        case (r_outBytes)
            3'd1:    data_out = {24'd0, w_rdata[31:24]};
            3'd2:    data_out = {16'd0, w_rdata[31:16]};
            3'd4:    data_out = w_rdata;
            default: data_out = 32'd0;
        endcase
        beat_valid = r_beatValid;
        moc        = (r_state == DONE);
        err        = (r_state == DONE) && w_bad;
    end

    ram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .i_addr  (w_ramAddr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width; memory depth = 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15, idle cycles inserted before every beat.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  request; held high for the whole transaction, dropped after moc.
REQ-006 read_write  input  1  1 = read, 0 = write.
REQ-007 data_length  input  2  0 BYTE, 1 HALFWORD, 2 WORD, 3 DOUBLEWORD.
REQ-008 address  input  ADDR_W  byte address of the first (most significant) byte.
REQ-009 data_in  input  32  write data; BYTE uses [7:0], HALFWORD uses [15:0].
REQ-010 data_out  output  32  read data, registered, big-endian.
REQ-011 beat_valid  output  1  one-cycle pulse per completed 32-bit beat.
REQ-012 moc  output  1  memory operation complete; held until enable drops.
REQ-013 err  output  1  range or alignment error, valid while moc is high.

Function
REQ-014 The FSM SHALL use states IDLE, WAIT, BEAT, DONE.
REQ-015 IDLE: enable=1 latches read_write, data_length, address and data_in, loads wait counter with WAIT_CYCLES, then goes to WAIT (or BEAT if WAIT_CYCLES=0).
REQ-016 WAIT: counter decrements each cycle; at 0 go to BEAT.
REQ-017 BEAT: one 32-bit beat per BEAT cycle (1..4 bytes), beat_valid pulses that cycle; DOUBLEWORD does 2 beats at address and address+4, with WAIT inserted between them; then go to DONE.
REQ-018 Byte order SHALL be big-endian: the lowest address holds the most significant byte of the beat.
REQ-019 Reads SHALL zero-extend BYTE and HALFWORD into data_out; data_out updates only in BEAT and otherwise holds.
REQ-020 DOUBLEWORD writes SHALL use the latched data_in for beat 0 and sample data_in in the cycle beat 1 executes.
REQ-021 Latency: enable sampled in IDLE at edge k gives beat 0 at edge k+1+WAIT_CYCLES and moc=1 after that edge. DOUBLEWORD adds 1+WAIT_CYCLES cycles.
REQ-022 DONE: moc=1 while enable=1; when enable=0, return to IDLE with moc=0 on the next edge.
REQ-023 Range check: if address + bytes > 2**ADDR_W, no memory access occurs; the FSM goes directly to DONE with err=1 after the wait, beat_valid stays 0 and data_out holds. No wrap-around.
REQ-024 If enable drops in WAIT or BEAT, the transaction aborts to IDLE with no further memory writes. Completed beats persist. moc and err stay 0.
REQ-025 A new request is accepted only from IDLE. A back-to-back request needs enable low for at least one cycle.

Reset
REQ-026 Reset SHALL force IDLE, moc=0, err=0, beat_valid=0, data_out=0 and counters=0, immediately and asynchronously, including mid-transaction.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro SYNC_RAM_ALIGN_CHECK_EN: when defined, an access whose address is not a multiple of its size (HALFWORD 2, WORD 4, DOUBLEWORD 4) SHALL behave like REQ-023: no access, err=1. When undefined, unaligned accesses SHALL proceed normally.

Structure
REQ-029 The data_length encodings (BYTE..DOUBLEWORD), the FSM state encoding and the byte-count function SHALL live in the shared package mem_pkg.
REQ-030 The byte array SHALL be a sub-module, ram_array: a synchronous 4-byte-lane read/write port with per-lane write enables, no reset.

Verification
REQ-031 WAIT_CYCLES=1: WORD write 0xDEADBEEF at address 0x010, then WORD read at 0x010 -> data_out=0xDEADBEEF, byte 0x010=0xDE, moc 2 cycles after accept.
REQ-032 BYTE read at 0x013 after REQ-031 -> data_out=0x000000EF. HALFWORD read at 0x011 -> 0x0000ADBE, or err=1 with SYNC_RAM_ALIGN_CHECK_EN.
REQ-033 DOUBLEWORD write at 0x020 with 0x11223344 then 0x55667788 -> two beat_valid pulses; read back gives the same values in order.
REQ-034 WORD write at 0x1FE (ADDR_W=9) -> err=1, moc=1, no bytes changed at 0x1FE/0x1FF.
REQ-035 Drop enable during WAIT of a DOUBLEWORD write (WAIT_CYCLES=3) after beat 0 -> 0x020..0x023 written, 0x024..0x027 unchanged, moc never rises.
REQ-036 Assert reset during BEAT -> all outputs 0 immediately, FSM in IDLE, earlier memory contents intact.
